alu_multicycle: RTL and testbench

- Parametrised, registered successor to the single-cycle datapath ALU.
- Keeps the existing ALUControl encoding.
- Adds a valid/ready handshake, registered outputs, and an iterative shift-add multiplier.
- Sits between the register-file read stage and the writeback mux of the multicycle datapath; the control FSM stalls on `ready`.

---
 rtl/alu_multicycle.sv | 198 +++++++++++++++++++
 tb/tb_alu_multicycle.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with a start/ready/done handshake and an
// iterative shift-add multiplier that consumes MUL_BITS_PER_CYCLE multiplier
// bits per clock. Single-cycle ops answer one cycle after accept.
//
// Handshake: start is taken only in a cycle where ready=1 (IDLE); a, b and
// ALUControl are sampled on that edge. done pulses for exactly one cycle, and
// result/zero (plus flags) are valid from that cycle until the next done.
// start while ready=0 is dropped silently.
//
// Optional macro ALU_MULTICYCLE_FLAGS_EN adds the registered negative, carry
// and overflow outputs. For MUL these flags need the full 2*WIDTH product.
module alu_multicycle #(
  parameter int WIDTH              = 64,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUControl,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef ALU_MULTICYCLE_FLAGS_EN
  ,
  output logic             negative,
  output logic             carry,
  output logic             overflow
`endif
);

  localparam int STEPS = WIDTH / MUL_BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
  localparam int MSB = WIDTH - 1;

`ifdef ALU_MULTICYCLE_FLAGS_EN
  // The carry flag of MUL looks at the high half of the product.
  localparam int ACC_W = 2 * WIDTH;
`else
  localparam int ACC_W = WIDTH;
`endif

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // state is left as a named signal so it can be probed hierarchically.
  state_t state;
  state_t state_next;

  logic [ACC_W-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] pp_sum;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_res;
  logic             accept;
  logic             is_mul;
  logic             mul_last;

  assign accept   = start && (state == S_IDLE);
  assign is_mul   = (ALUControl == OP_MUL);
  assign mul_last = (state == S_MUL) && (cnt == LAST_STEP);

  // State register; reset dominates everything else.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = is_mul ? S_MUL : S_DONE;
      S_MUL:  if (cnt == LAST_STEP) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    ready = (state == S_IDLE);
    done  = (state == S_DONE);
  end

  // Single-cycle ops; unknown codes yield zero.
  always_comb begin
    op_res = '0;
    case (ALUControl)
      OP_AND:  op_res = a & b;
      OP_OR:   op_res = a | b;
      OP_ADD:  op_res = a + b;
      OP_XOR:  op_res = a ^ b;
      OP_SUB:  op_res = a - b;
      OP_PASS: op_res = b;
      default: op_res = '0;
    endcase
  end

  // Partial products for this step's multiplier bits, added to the accumulator.
  always_comb begin
    pp_sum = acc;
    for (int j = 0; j < MUL_BITS_PER_CYCLE; j++) begin
      if (mplier[j]) pp_sum = pp_sum + (mcand << j);
    end
  end

`ifdef ALU_MULTICYCLE_FLAGS_EN
  logic [WIDTH:0]   add_ext;
  logic [WIDTH-1:0] dif_w;
  logic             op_carry;
  logic             op_ovf;

  // Carry/overflow of the single-cycle ops.
  always_comb begin
    add_ext  = {1'b0, a} + {1'b0, b};
    dif_w    = a - b;
    op_carry = 1'b0;
    op_ovf   = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        op_carry = add_ext[WIDTH];
        op_ovf   = (a[MSB] == b[MSB]) && (add_ext[MSB] != a[MSB]);
      end
      OP_SUB: begin
        op_carry = (a >= b);
        op_ovf   = (a[MSB] != b[MSB]) && (dif_w[MSB] != a[MSB]);
      end
      default: begin
        op_carry = 1'b0;
        op_ovf   = 1'b0;
      end
    endcase
  end
`endif

  // Datapath: operand latch, multiply iteration and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      zero   <= 1'b1;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
`ifdef ALU_MULTICYCLE_FLAGS_EN
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
`endif
    end else if (accept) begin
      if (is_mul) begin
        mcand  <= ACC_W'(a);
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        result <= op_res;
        zero   <= (op_res == '0);
`ifdef ALU_MULTICYCLE_FLAGS_EN
        negative <= op_res[MSB];
        carry    <= op_carry;
        overflow <= op_ovf;
`endif
      end
    end else if (state == S_MUL) begin
      acc    <= pp_sum;
      mcand  <= mcand << MUL_BITS_PER_CYCLE;
      mplier <= mplier >> MUL_BITS_PER_CYCLE;
      cnt    <= cnt + CNT_W'(1);
      if (mul_last) begin
        result <= pp_sum[WIDTH-1:0];
        zero   <= (pp_sum[WIDTH-1:0] == '0);
`ifdef ALU_MULTICYCLE_FLAGS_EN
        negative <= pp_sum[MSB];
        carry    <= |pp_sum[ACC_W-1:WIDTH];
        overflow <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: a 64-bit/1-bit-per-cycle instance and an
// 8-bit/2-bits-per-cycle instance share clock and reset. Directed scenarios
// come first, then random operations checked against an arithmetic model.
module tb_alu_multicycle;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 64-bit instance signals
  logic        start;
  logic [63:0] a, b;
  logic [3:0]  ctl;
  logic        ready, done, zero;
  logic [63:0] result;
  // 8-bit instance signals
  logic        start8;
  logic [7:0]  a8, b8;
  logic [3:0]  ctl8;
  logic        ready8, done8, zero8;
  logic [7:0]  result8;
`ifdef ALU_MULTICYCLE_FLAGS_EN
  logic negative, carry, overflow;
  logic negative8, carry8, overflow8;
`endif

  alu_multicycle #(.WIDTH(64), .MUL_BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ALUControl(ctl),
    .ready(ready), .done(done), .result(result), .zero(zero)
`ifdef ALU_MULTICYCLE_FLAGS_EN
    , .negative(negative), .carry(carry), .overflow(overflow)
`endif
  );

  alu_multicycle #(.WIDTH(8), .MUL_BITS_PER_CYCLE(2)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .ALUControl(ctl8),
    .ready(ready8), .done(done8), .result(result8), .zero(zero8)
`ifdef ALU_MULTICYCLE_FLAGS_EN
    , .negative(negative8), .carry(carry8), .overflow(overflow8)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [63:0] res;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        ovf;
  } exp_t;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the operation on w-bit unsigned operands done with wide
  // integer arithmetic, flags derived from signed/unsigned value ranges.
  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input logic [63:0] x, input logic [63:0] y);
    exp_t e;
    logic [127:0] mask, xx, yy, full, r;
    logic signed [127:0] sx, sy, s, lim_hi, lim_lo;
    logic c, v;
    mask   = (128'd1 << w) - 128'd1;
    xx     = {64'd0, x} & mask;
    yy     = {64'd0, y} & mask;
    sx     = $signed(xx << (128 - w)) >>> (128 - w);
    sy     = $signed(yy << (128 - w)) >>> (128 - w);
    lim_hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lim_lo = -(128'sd1 <<< (w - 1));
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (op)
      4'b0000: r = xx & yy;
      4'b0001: r = xx | yy;
      4'b0011: r = xx ^ yy;
      4'b0111: r = yy;
      4'b0010: begin
        full = xx + yy;
        r = full & mask;
        c = (full >> w) != 0;
        s = sx + sy;
        v = (s > lim_hi) || (s < lim_lo);
      end
      4'b0110: begin
        r = (xx - yy) & mask;
        c = (xx >= yy);
        s = sx - sy;
        v = (s > lim_hi) || (s < lim_lo);
      end
      4'b1000: begin
        full = xx * yy;
        r = full & mask;
        c = (full >> w) != 0;
      end
      default: r = '0;
    endcase
    e.res   = r[63:0];
    e.zero  = (r == 0);
    e.neg   = ((r >> (w - 1)) & 128'd1) != 0;
    e.carry = c;
    e.ovf   = v;
    return e;
  endfunction

  function automatic logic get_rdy(input bit sel);
    return sel ? ready8 : ready;
  endfunction
  function automatic logic get_done(input bit sel);
    return sel ? done8 : done;
  endfunction
  function automatic logic [63:0] get_res(input bit sel);
    return sel ? {56'd0, result8} : result;
  endfunction
  function automatic logic get_zero(input bit sel);
    return sel ? zero8 : zero;
  endfunction

  task automatic drive(input bit sel, input logic s, input logic [3:0] op,
                       input logic [63:0] x, input logic [63:0] y);
    if (sel) begin
      start8 = s; ctl8 = op; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      start = s; ctl = op; a = x; b = y;
    end
  endtask

  task automatic check_flags(input bit sel, input string tag, input exp_t e);
`ifdef ALU_MULTICYCLE_FLAGS_EN
    check({tag, "/negative"}, sel ? negative8 : negative, e.neg);
    check({tag, "/carry"},    sel ? carry8 : carry,       e.carry);
    check({tag, "/overflow"}, sel ? overflow8 : overflow, e.ovf);
`endif
  endtask

  // One full transaction: accept, then inputs are scrambled (and optionally
  // start is held high with another opcode) while busy; checks latency, the
  // done-cycle outputs and that the result holds into the following IDLE.
  task automatic do_op(input bit sel, input logic [3:0] op, input logic [63:0] x,
                       input logic [63:0] y, input exp_t e, input int exp_lat,
                       input bit poke, input string tag);
    int lat;
    bit busy_ok;
    @(negedge clk);
    check({tag, "/ready_idle"}, get_rdy(sel), 1'b1);
    drive(sel, 1'b1, op, x, y);
    @(negedge clk);
    drive(sel, poke, 4'b0010, ~x, ~y);
    lat = 1;
    busy_ok = 1'b1;
    while (!get_done(sel) && lat < 200) begin
      if (get_rdy(sel) !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    drive(sel, 1'b0, 4'b0000, 64'd0, 64'd0);
    check({tag, "/busy_ready_low"}, busy_ok, 1'b1);
    check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/done"}, get_done(sel), 1'b1);
    check({tag, "/ready_in_done"}, get_rdy(sel), 1'b0);
    check({tag, "/result"}, get_res(sel), e.res);
    check({tag, "/zero"}, get_zero(sel), e.zero);
    check_flags(sel, tag, e);
    @(negedge clk);
    check({tag, "/ready_after"}, get_rdy(sel), 1'b1);
    check({tag, "/done_after"}, get_done(sel), 1'b0);
    check({tag, "/result_held"}, get_res(sel), e.res);
  endtask

  initial begin
    logic [3:0] ops [10];
    exp_t e;
    logic [63:0] x, y;
    logic [3:0] op;
    bit sel, poke;
    int w, lat;

    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0111,
            4'b1000, 4'b1000, 4'b0100, 4'b1111};
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'b0000, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 4'b0000, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    check("reset/ready", ready, 1'b1);
    check("reset/done", done, 1'b0);
    check("reset/result", result, 64'd0);
    check("reset/zero", zero, 1'b1);
    check("reset8/ready", ready8, 1'b1);
    check("reset8/result", result8, 8'd0);
`ifdef ALU_MULTICYCLE_FLAGS_EN
    check("reset/flags", {negative, carry, overflow}, 3'b000);
`endif
    reset = 1'b0;

    e = '{res: 64'd93873887066333352, zero: 1'b0, neg: 1'b0, carry: 1'b0, ovf: 1'b0};
    do_op(1'b0, 4'b0010, 64'd93846573825364758, 64'd27313240968594, e, 1, 1'b0, "add");

    e = '{res: 64'd18352924813125155452, zero: 1'b0, neg: 1'b1, carry: 1'b0, ovf: 1'b0};
    do_op(1'b0, 4'b0110, 64'd27313240968594, 64'd93846573825364758, e, 1, 1'b0, "sub");

    e = '{res: 64'd21, zero: 1'b0, neg: 1'b0, carry: 1'b0, ovf: 1'b0};
    do_op(1'b0, 4'b1000, 64'd3, 64'd7, e, 65, 1'b1, "mul3x7");

    e = '{res: 64'd9223372036854775809, zero: 1'b0, neg: 1'b1, carry: 1'b0, ovf: 1'b1};
    do_op(1'b0, 4'b0010, 64'd9223372036854775807, 64'd2, e, 1, 1'b0, "add_ovf");

    e = '{res: 64'd0, zero: 1'b1, neg: 1'b0, carry: 1'b0, ovf: 1'b0};
    do_op(1'b0, 4'b0000, 64'd27586970463758451, 64'd18419157103245793164, e, 1, 1'b0, "and_zero");

    e = '{res: 64'd0, zero: 1'b1, neg: 1'b0, carry: 1'b0, ovf: 1'b0};
    do_op(1'b0, 4'b1101, 64'hDEAD, 64'hBEEF, e, 1, 1'b0, "undef");

    // Reset ten cycles into a long multiply discards it.
    @(negedge clk);
    drive(1'b0, 1'b1, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset/ready", ready, 1'b1);
    check("midreset/done", done, 1'b0);
    check("midreset/result", result, 64'd0);
    check("midreset/zero", zero, 1'b1);

    e = '{res: 64'hFF, zero: 1'b0, neg: 1'b0, carry: 1'b0, ovf: 1'b0};
    do_op(1'b0, 4'b0011, 64'hF0, 64'h0F, e, 1, 1'b0, "xor");

    e = model(64, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    do_op(1'b0, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, e, 65, 1'b0, "mul_full");

    e = '{res: 64'd88, zero: 1'b0, neg: 1'b0, carry: 1'b1, ovf: 1'b0};
    do_op(1'b1, 4'b1000, 64'd200, 64'd3, e, 5, 1'b1, "mul8");

    for (int i = 0; i < 40; i++) begin
      sel  = ($urandom_range(0, 1) == 1);
      op   = ops[$urandom_range(0, 9)];
      poke = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 5))
        0:       x = 64'hFFFF_FFFF_FFFF_FFFF;
        1:       x = 64'h8000_0000_0000_0080;
        default: x = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 5))
        0:       y = 64'd0;
        1:       y = 64'h7FFF_FFFF_FFFF_FF7F;
        default: y = {$urandom, $urandom};
      endcase
      w   = sel ? 8 : 64;
      lat = (op == 4'b1000) ? (sel ? 5 : 65) : 1;
      e   = model(w, op, x, y);
      do_op(sel, op, x, y, e, lat, poke, $sformatf("rand%0d_op%0h_w%0d", i, op, w));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
